// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared widths, source encodings and payload type for the write-back arbiter.
// Optional perf counters in the top are enabled with E203_WBCK_ARB_PERF_EN.
package e203_exu_wbck_arb_pkg;

  localparam int E203_XLEN        = 32;
  localparam int E203_FLEN        = 64;
  localparam int E203_RFIDX_WIDTH = 5;

  localparam logic [2:0] E203_WBCK_SRC_ALU = 3'b001;
  localparam logic [2:0] E203_WBCK_SRC_LSU = 3'b010;
  localparam logic [2:0] E203_WBCK_SRC_MDV = 3'b100;

  typedef struct packed {
    logic [E203_FLEN-1:0]        wdat;
    logic [E203_RFIDX_WIDTH-1:0] rdidx;
    logic [4:0]                  flags;
    logic                        rdfpu;
  } wbck_pld_t;

endpackage

// File: rtl/e203_exu_wbck_rr.sv
// Two-requester round-robin grant for the long pipes (bit 0 = LSU, bit 1 = MDV).
module e203_exu_wbck_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a grant the pointer favours whichever pipe did not win.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (upd) rr_ptr_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Registered write-back arbiter: long pipes over ALU, starvation guard for ALU.
// Define E203_WBCK_ARB_PERF_EN to add the stall/force performance counters.
module e203_exu_wbck_arb
  import e203_exu_wbck_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int STARVE_CW  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_wbck_i_valid,
  output logic                        alu_wbck_i_ready,
  input  logic [E203_XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [E203_RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                        lsu_wbck_i_valid,
  output logic                        lsu_wbck_i_ready,
  input  logic [E203_FLEN-1:0]        lsu_wbck_i_wdat,
  input  logic [E203_RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx,
  input  logic                        lsu_wbck_i_rdfpu,
  input  logic                        mdv_wbck_i_valid,
  output logic                        mdv_wbck_i_ready,
  input  logic [E203_FLEN-1:0]        mdv_wbck_i_wdat,
  input  logic [4:0]                  mdv_wbck_i_flags,
  input  logic [E203_RFIDX_WIDTH-1:0] mdv_wbck_i_rdidx,
  input  logic                        mdv_wbck_i_rdfpu,
`ifdef E203_WBCK_ARB_PERF_EN
  output logic [31:0]                 perf_alu_stall_cnt,
  output logic [15:0]                 perf_force_cnt,
`endif
  output logic                        rf_wbck_o_ena,
  output logic                        frf_wbck_o_ena,
  output logic [E203_FLEN-1:0]        wbck_o_wdat,
  output logic [E203_RFIDX_WIDTH-1:0] wbck_o_rdidx,
  output logic                        wbck_o_flags_ena,
  output logic [4:0]                  wbck_o_flags
);

  logic                 force_alu;
  logic                 grant_any;
  logic [1:0]           long_req;
  logic [1:0]           long_gnt;
  logic [2:0]           gnt_vec;
  wbck_pld_t            pld_sel;
  logic [STARVE_CW-1:0] starve_cnt_q, starve_cnt_d;

  logic                        rf_ena_q, rf_ena_d;
  logic                        frf_ena_q, frf_ena_d;
  logic                        flags_ena_q, flags_ena_d;
  logic [E203_FLEN-1:0]        wdat_q, wdat_d;
  logic [E203_RFIDX_WIDTH-1:0] rdidx_q, rdidx_d;
  logic [4:0]                  flags_q, flags_d;

  assign force_alu = alu_wbck_i_valid & (starve_cnt_q == STARVE_CW'(STARVE_MAX));
  assign long_req  = {mdv_wbck_i_valid, lsu_wbck_i_valid} & {2{~force_alu}};

  e203_exu_wbck_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (long_req),
    .upd   (|long_gnt),
    .gnt   (long_gnt)
  );

  always_comb begin
    gnt_vec = 3'b000;
    if (force_alu)             gnt_vec = E203_WBCK_SRC_ALU;
    else if (long_gnt[0])      gnt_vec = E203_WBCK_SRC_LSU;
    else if (long_gnt[1])      gnt_vec = E203_WBCK_SRC_MDV;
    else if (alu_wbck_i_valid) gnt_vec = E203_WBCK_SRC_ALU;
  end

  assign grant_any        = |gnt_vec;
  assign alu_wbck_i_ready = |(gnt_vec & E203_WBCK_SRC_ALU);
  assign lsu_wbck_i_ready = |(gnt_vec & E203_WBCK_SRC_LSU);
  assign mdv_wbck_i_ready = |(gnt_vec & E203_WBCK_SRC_MDV);

  // ALU writes only the integer file, so its data is zero-extended with no flags.
  always_comb begin
    pld_sel = '0;
    if (lsu_wbck_i_ready) begin
      pld_sel.wdat  = lsu_wbck_i_wdat;
      pld_sel.rdidx = lsu_wbck_i_rdidx;
      pld_sel.rdfpu = lsu_wbck_i_rdfpu;
    end else if (mdv_wbck_i_ready) begin
      pld_sel.wdat  = mdv_wbck_i_wdat;
      pld_sel.rdidx = mdv_wbck_i_rdidx;
      pld_sel.flags = mdv_wbck_i_flags;
      pld_sel.rdfpu = mdv_wbck_i_rdfpu;
    end else begin
      pld_sel.wdat[E203_XLEN-1:0] = alu_wbck_i_wdat;
      pld_sel.rdidx               = alu_wbck_i_rdidx;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_wbck_i_valid || alu_wbck_i_ready)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_CW'(STARVE_MAX))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_comb begin
    rf_ena_d    = grant_any & ~pld_sel.rdfpu;
    frf_ena_d   = grant_any & pld_sel.rdfpu;
    flags_ena_d = mdv_wbck_i_ready & mdv_wbck_i_rdfpu;
    wdat_d      = grant_any ? pld_sel.wdat  : wdat_q;
    rdidx_d     = grant_any ? pld_sel.rdidx : rdidx_q;
    flags_d     = grant_any ? pld_sel.flags : flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_ena_q     <= 1'b0;
      frf_ena_q    <= 1'b0;
      flags_ena_q  <= 1'b0;
      wdat_q       <= '0;
      rdidx_q      <= '0;
      flags_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_ena_q     <= rf_ena_d;
      frf_ena_q    <= frf_ena_d;
      flags_ena_q  <= flags_ena_d;
      wdat_q       <= wdat_d;
      rdidx_q      <= rdidx_d;
      flags_q      <= flags_d;
    end
  end

  assign rf_wbck_o_ena    = rf_ena_q;
  assign frf_wbck_o_ena   = frf_ena_q;
  assign wbck_o_flags_ena = flags_ena_q;
  assign wbck_o_wdat      = wdat_q;
  assign wbck_o_rdidx     = rdidx_q;
  assign wbck_o_flags     = flags_q;

`ifdef E203_WBCK_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_force_q, perf_force_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, alu_wbck_i_valid & ~alu_wbck_i_ready};
    perf_force_d = perf_force_q + {15'd0, force_alu};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_force_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_force_q <= perf_force_d;
    end
  end

  assign perf_alu_stall_cnt = perf_stall_q;
  assign perf_force_cnt     = perf_force_q;
`endif

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Self-checking bench for e203_exu_wbck_arb: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_e203_exu_wbck_arb;
  import e203_exu_wbck_arb_pkg::*;

  localparam int SMAX = 4;
  localparam int W_NONE = 0, W_ALU = 1, W_LSU = 2, W_MDV = 3;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        alu_valid = 1'b0, lsu_valid = 1'b0, mdv_valid = 1'b0;
  logic                        alu_ready, lsu_ready, mdv_ready;
  logic [E203_XLEN-1:0]        alu_wdat = '0;
  logic [E203_RFIDX_WIDTH-1:0] alu_rdidx = '0, lsu_rdidx = '0, mdv_rdidx = '0;
  logic [E203_FLEN-1:0]        lsu_wdat = '0, mdv_wdat = '0;
  logic                        lsu_rdfpu = 1'b0, mdv_rdfpu = 1'b0;
  logic [4:0]                  mdv_flags = '0;
  logic                        rf_ena, frf_ena, flags_ena;
  logic [E203_FLEN-1:0]        o_wdat;
  logic [E203_RFIDX_WIDTH-1:0] o_rdidx;
  logic [4:0]                  o_flags;
`ifdef E203_WBCK_ARB_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_force;
`endif

  e203_exu_wbck_arb #(.STARVE_MAX(SMAX), .STARVE_CW(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_wbck_i_valid (alu_valid),
    .alu_wbck_i_ready (alu_ready),
    .alu_wbck_i_wdat  (alu_wdat),
    .alu_wbck_i_rdidx (alu_rdidx),
    .lsu_wbck_i_valid (lsu_valid),
    .lsu_wbck_i_ready (lsu_ready),
    .lsu_wbck_i_wdat  (lsu_wdat),
    .lsu_wbck_i_rdidx (lsu_rdidx),
    .lsu_wbck_i_rdfpu (lsu_rdfpu),
    .mdv_wbck_i_valid (mdv_valid),
    .mdv_wbck_i_ready (mdv_ready),
    .mdv_wbck_i_wdat  (mdv_wdat),
    .mdv_wbck_i_flags (mdv_flags),
    .mdv_wbck_i_rdidx (mdv_rdidx),
    .mdv_wbck_i_rdfpu (mdv_rdfpu),
`ifdef E203_WBCK_ARB_PERF_EN
    .perf_alu_stall_cnt (perf_stall),
    .perf_force_cnt     (perf_force),
`endif
    .rf_wbck_o_ena    (rf_ena),
    .frf_wbck_o_ena   (frf_ena),
    .wbck_o_wdat      (o_wdat),
    .wbck_o_rdidx     (o_rdidx),
    .wbck_o_flags_ena (flags_ena),
    .wbck_o_flags     (o_flags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: starvation count, round-robin preference,
  // and the write the regfile should currently be seeing.
  int                          m_starve;
  int                          m_pref_mdv;
  bit                          e_rf, e_frf, e_fe;
  logic [E203_FLEN-1:0]        e_wdat;
  logic [E203_RFIDX_WIDTH-1:0] e_rdidx;
  logic [4:0]                  e_flags;
  int                          last_win;
  logic [2:0]                  last_rdy;
  longint                      m_stall_cnt, m_force_cnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_starve = 0; m_pref_mdv = 0;
    e_rf = 0; e_frf = 0; e_fe = 0;
    e_wdat = '0; e_rdidx = '0; e_flags = '0;
    m_stall_cnt = 0; m_force_cnt = 0;
  endtask

  task automatic applyStimulus(input bit av, input bit lv, input bit mv);
    alu_valid = av; lsu_valid = lv; mdv_valid = mv;
  endtask

  task automatic applyReset();
    applyStimulus(0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
  endtask

  // One cycle: predict and compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int  win;
    bit  forced;
    bit  w_fpu;
    logic [E203_FLEN-1:0]        w_wdat;
    logic [E203_RFIDX_WIDTH-1:0] w_idx;
    logic [4:0]                  w_flags;
    @(negedge clk);
    forced = alu_valid && (m_starve == SMAX);
    if (forced)                  win = W_ALU;
    else if (lsu_valid && mdv_valid) win = m_pref_mdv ? W_MDV : W_LSU;
    else if (lsu_valid)          win = W_LSU;
    else if (mdv_valid)          win = W_MDV;
    else if (alu_valid)          win = W_ALU;
    else                         win = W_NONE;

    checkOutput("alu_ready", alu_ready, (win == W_ALU));
    checkOutput("lsu_ready", lsu_ready, (win == W_LSU));
    checkOutput("mdv_ready", mdv_ready, (win == W_MDV));
    checkOutput("rf_ena", rf_ena, e_rf);
    checkOutput("frf_ena", frf_ena, e_frf);
    checkOutput("flags_ena", flags_ena, e_fe);
    checkOutput("wdat", o_wdat, e_wdat);
    checkOutput("rdidx", o_rdidx, e_rdidx);
    checkOutput("flags", o_flags, e_flags);
`ifdef E203_WBCK_ARB_PERF_EN
    checkOutput("perf_stall", perf_stall, m_stall_cnt[31:0]);
    checkOutput("perf_force", perf_force, m_force_cnt[15:0]);
`endif
    last_win = win;
    last_rdy = {mdv_ready, lsu_ready, alu_ready};

    w_fpu = 0; w_flags = '0; w_wdat = '0; w_idx = '0;
    case (win)
      W_ALU: begin w_wdat = {32'd0, alu_wdat}; w_idx = alu_rdidx; end
      W_LSU: begin w_wdat = lsu_wdat; w_idx = lsu_rdidx; w_fpu = lsu_rdfpu; end
      W_MDV: begin w_wdat = mdv_wdat; w_idx = mdv_rdidx; w_fpu = mdv_rdfpu; w_flags = mdv_flags; end
      default: ;
    endcase

    @(posedge clk);
    e_rf  = (win != W_NONE) && !w_fpu;
    e_frf = (win != W_NONE) && w_fpu;
    e_fe  = (win == W_MDV) && w_fpu;
    if (win != W_NONE) begin
      e_wdat = w_wdat; e_rdidx = w_idx; e_flags = w_flags;
    end
    if (alu_valid && win != W_ALU) begin
      m_stall_cnt++;
      m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    end else begin
      m_starve = 0;
    end
    if (forced) m_force_cnt++;
    if (win == W_LSU) m_pref_mdv = 1;
    if (win == W_MDV) m_pref_mdv = 0;
    #1;
  endtask

  initial begin : main
    int exp_seq[6];
    modelReset();
    applyReset();
    checkOutput("reset_rf_ena", rf_ena, 0);
    checkOutput("reset_wdat", o_wdat, 0);

    // ALU alone: accepted immediately, written the following cycle.
    alu_rdidx = 5'd5; alu_wdat = 32'h1234;
    applyStimulus(1, 0, 0);
    step();
    checkOutput("alu_only_ready", last_rdy, 3'b001);
    checkOutput("alu_only_rf_ena", rf_ena, 1);
    checkOutput("alu_only_rdidx", o_rdidx, 5);
    checkOutput("alu_only_wdat", o_wdat, 64'h1234);
    checkOutput("alu_only_frf_ena", frf_ena, 0);

    // LSU beats ALU twice, then ALU gets through once LSU drops.
    lsu_wdat = 64'hDEAD_BEEF_0000_0001; lsu_rdidx = 5'd7;
    applyStimulus(1, 1, 0);
    step(); checkOutput("lsu_alu_c0", last_rdy, 3'b010);
    step(); checkOutput("lsu_alu_c1", last_rdy, 3'b010);
    checkOutput("lsu_alu_starve", m_starve, 2);
    applyStimulus(1, 0, 0);
    step(); checkOutput("lsu_drop_alu", last_rdy, 3'b001);
    checkOutput("lsu_drop_starve", m_starve, 0);

    // Both long pipes from reset alternate, LSU first.
    applyReset();
    mdv_wdat = 64'h55; mdv_rdidx = 5'd9;
    applyStimulus(0, 1, 1);
    exp_seq = '{W_LSU, W_MDV, W_LSU, W_MDV, 0, 0};
    for (int i = 0; i < 4; i++) begin
      step(); checkOutput("rr_seq", last_win, exp_seq[i]);
    end

    // All three: four long-pipe wins, a forced ALU win, then LSU resumes.
    applyReset();
    applyStimulus(1, 1, 1);
    exp_seq = '{W_LSU, W_MDV, W_LSU, W_MDV, W_ALU, W_LSU};
    for (int i = 0; i < 6; i++) begin
      step(); checkOutput("starve_seq", last_win, exp_seq[i]);
    end

    // FP write from MDV raises the flags strobe.
    applyReset();
    mdv_rdfpu = 1'b1; mdv_flags = 5'b00101; mdv_rdidx = 5'd3;
    applyStimulus(0, 0, 1);
    step();
    checkOutput("fp_frf_ena", frf_ena, 1);
    checkOutput("fp_flags_ena", flags_ena, 1);
    checkOutput("fp_flags", o_flags, 5'b00101);
    checkOutput("fp_rf_ena", rf_ena, 0);
    checkOutput("fp_rdidx", o_rdidx, 3);
    mdv_rdfpu = 1'b0; mdv_flags = '0;

    // Reset right after an ALU grant drops the pending write at once.
    applyStimulus(1, 0, 0);
    step();
    checkOutput("pre_reset_rf_ena", rf_ena, 1);
    applyStimulus(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_rf_ena", rf_ena, 0);
    modelReset();
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(0, 1, 1);
    step(); checkOutput("post_reset_rr", last_win, W_LSU);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      alu_wdat  = $urandom;
      alu_rdidx = E203_RFIDX_WIDTH'($urandom);
      lsu_wdat  = {$urandom, $urandom};
      lsu_rdidx = E203_RFIDX_WIDTH'($urandom);
      lsu_rdfpu = 1'($urandom);
      mdv_wdat  = {$urandom, $urandom};
      mdv_rdidx = E203_RFIDX_WIDTH'($urandom);
      mdv_rdfpu = 1'($urandom);
      mdv_flags = 5'($urandom);
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
                    $urandom_range(0, 9) < 5);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
